demux_latch: RTL

//  Serial-to-parallel companion of the Mux/Latch primitives: one WIDTH-bit

---
 rtl/demux_latch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/demux_latch.sv
// ---------------------------------------------------------------------------
// demux_latch
//   Serial-to-parallel demultiplexing latch. A stream of WIDTH-bit writes is
//   steered slot by slot into LANES latched slots. Once every slot of a frame
//   has been written, the frame is held stable and flagged valid until the
//   consumer acknowledges it.
//
// Parameters
//   WIDTH  bits per slot
//   LANES  slots per frame (>= 1)
//
// Ports
//   clk       in   clock, all state updates on posedge
//   reset     in   synchronous, active-high; beats every other input
//   write_en  in   write `in` into the current slot
//   in        in   write data (WIDTH)
//   ack       in   consumer takes the held frame (looked at only while valid=1)
//   ready     out  1 while filling (combinational from state)
//   idx       out  slot the next accepted write goes to
//   out       out  slot k at out[k*WIDTH +: WIDTH]
//   valid     out  registered; 1 while a complete frame is held
//   overrun   out  sticky; a write arrived while ready=0
//
// Optional feature (macro DEMUX_LATCH_FLUSH_EN):
//   flush     in   close a partial frame early
//   len       out  number of valid slots in the held frame
//
// Handshake: producer side is a valid/ready pair where write_en is the valid.
// A write transfers only in a cycle with write_en=1 and ready=1; a write with
// ready=0 is dropped and flagged on overrun. Consumer side: the frame on out
// transfers in the cycle valid=1 and ack=1; ack with valid=0 has no effect.
// ---------------------------------------------------------------------------
module demux_latch #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1
`ifdef DEMUX_LATCH_FLUSH_EN
   ,
   localparam int LW = $clog2(LANES + 1)
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   write_en,
   input  logic [WIDTH-1:0]       in,
   input  logic                   ack,
`ifdef DEMUX_LATCH_FLUSH_EN
   input  logic                   flush,
   output logic [LW-1:0]          len,
`endif
   output logic                   ready,
   output logic [IW-1:0]          idx,
   output logic [LANES*WIDTH-1:0] out,
   output logic                   valid,
   output logic                   overrun
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                        state;
   logic [LANES-1:0][WIDTH-1:0]   slots;
   logic                          last_slot;
   logic                          flush_req;

`ifdef DEMUX_LATCH_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign last_slot = (idx == IW'(LANES - 1));
   assign ready     = (state == FILL);
   // Packed slot array already has slot k at bits [k*WIDTH +: WIDTH].
   assign out       = slots;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FILL;
         slots   <= '0;
         idx     <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
`ifdef DEMUX_LATCH_FLUSH_EN
         len     <= '0;
`endif
      end else begin
         case (state)
            FILL: begin
               if (write_en) begin
                  for (int k = 0; k < LANES; k++) begin
                     if (idx == IW'(k)) slots[k] <= in;
                  end
                  if (last_slot) begin
                     idx   <= '0;
                     state <= HOLD;
                     valid <= 1'b1;
`ifdef DEMUX_LATCH_FLUSH_EN
                     len   <= LW'(LANES);
`endif
                  end else if (flush_req) begin
                     // Accept this write, then close the frame behind it.
                     idx   <= '0;
                     state <= HOLD;
                     valid <= 1'b1;
`ifdef DEMUX_LATCH_FLUSH_EN
                     len   <= LW'(idx) + LW'(1);
`endif
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else if (flush_req && (idx != '0)) begin
                  // Partial frame: unwritten slots keep the previous frame.
                  idx   <= '0;
                  state <= HOLD;
                  valid <= 1'b1;
`ifdef DEMUX_LATCH_FLUSH_EN
                  len   <= LW'(idx);
`endif
               end
            end
            HOLD: begin
               // A write in HOLD is always dropped, even alongside an ack.
               if (write_en) overrun <= 1'b1;
               if (ack) begin
                  state <= FILL;
                  valid <= 1'b0;
               end
            end
            default: begin
               state <= FILL;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
